// File: rtl/data_ram_if.sv
// Core-side RAM bus plus the console byte stream of the data_ram responder.
// The master modport is the core/consumer side; the slave modport is the memory.
interface data_ram_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output ce, we, addr, sel, data_i, tx_ready,
    input  data_o, tx_valid, tx_data
  );

  modport slave (
    input  ce, we, addr, sel, data_i, tx_ready,
    output data_o, tx_valid, tx_data
  );
endinterface

// File: rtl/data_ram.sv
// Word RAM with byte-lane writes and combinational read, fronted by an optional MMIO
// window (cycle counter, console byte FIFO, status) enabled by DATA_RAM_MMIO_EN.
module data_ram #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [3:0] MMIO_TAG   = 4'hF,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  data_ram_if.slave  bus
);

  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [31:0]           mem [WORDS];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           mem_word;
  logic [31:0]           mmio_rdata;
  logic                  mmio_hit;
  logic                  ram_we;
  logic                  rd_en;
  logic                  unused_bits;

  assign word_idx    = bus.addr[ADDR_WIDTH+1:2];
  assign mem_word    = mem[word_idx];
  assign rd_en       = bus.ce & ~bus.we;
  assign unused_bits = ^{bus.addr, bus.data_i, bus.tx_ready};

  // RAM contents survive reset; only the write issued during the reset cycle is dropped.
  assign ram_we = bus.ce & bus.we & ~mmio_hit & ~rst;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && bus.sel[i]) begin
        mem[word_idx][i*8 +: 8] <= bus.data_i[i*8 +: 8];
      end
    end
  end

  assign bus.data_o = rd_en ? (mmio_hit ? mmio_rdata : mem_word) : 32'h0;

`ifdef DATA_RAM_MMIO_EN
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   cycle_reg;
  logic [7:0]    fifo_mem_reg [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic [1:0]    offset;
  logic          mmio_wr;
  logic          enq_req;
  logic          enq_ok;
  logic          deq;
  logic          status_wr;
  logic          fifo_full;
  logic          fifo_empty;

  assign mmio_hit   = (bus.addr[31:28] == MMIO_TAG);
  assign offset     = bus.addr[3:2];
  assign mmio_wr    = bus.ce & bus.we & mmio_hit;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
  assign deq        = ~fifo_empty & bus.tx_ready;
  assign enq_req    = mmio_wr & (offset == 2'd1) & bus.sel[0];
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign enq_ok     = enq_req & (~fifo_full | deq);
  assign status_wr  = mmio_wr & (offset == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      if (enq_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (deq)    rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({enq_ok, deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (status_wr)             overflow_reg <= 1'b0;
      else if (enq_req & ~enq_ok) overflow_reg <= 1'b1;
    end
  end

  // Storage is cleared on reset so tx_data reads 0 while the FIFO is empty after reset.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        fifo_mem_reg[gi] <= 8'h0;
      end else if (enq_ok && (wr_ptr_reg == PW'(gi))) begin
        fifo_mem_reg[gi] <= bus.data_i[7:0];
      end
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (offset)
      2'd0:    mmio_rdata = cycle_reg;
      2'd2:    mmio_rdata = {16'h0, 8'(count_reg), 5'h0, overflow_reg, fifo_full, fifo_empty};
      default: mmio_rdata = 32'h0;
    endcase
  end

  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_mem_reg[rd_ptr_reg];
`else
  assign mmio_hit     = 1'b0;
  assign mmio_rdata   = 32'h0;
  assign bus.tx_valid = 1'b0;
  assign bus.tx_data  = 8'h0;
`endif

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: read results and console bytes are queued as
// expectations when stimulus is driven and compared when the DUT presents them.
module tb_data_ram;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] model [16];

  data_ram_if bus ();

  data_ram #(
    .ADDR_WIDTH (10),
    .MMIO_TAG   (4'hF),
    .FIFO_DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got %08h", tag, got);
    end else begin
      $display("FAIL %-16s got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.ce     = 1'b1;
    bus.we     = 1'b1;
    bus.addr   = a;
    bus.data_i = d;
    bus.sel    = s;
    tick();
    bus.ce = 1'b0;
    bus.we = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] e);
    bus.ce   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    bus.sel  = 4'b0000;
    exp_q.push_back(e);
    #2;
    check(tag, bus.data_o, exp_q.pop_front());
    bus.ce = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    bus.tx_ready = 1'b1;
    while (tx_q.size() > 0 && cyc < budget) begin
      if (bus.tx_valid) check(tag, {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
      tick();
      cyc++;
    end
    if (tx_q.size() != 0) check("drain_timeout", tx_q.size(), 32'd0);
    bus.tx_ready = 1'b0;
    check("drain_empty", {31'h0, bus.tx_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  s;
    int          idx;
    n_checks     = 0;
    n_pass       = 0;
    rst          = 1'b1;
    bus.ce       = 1'b0;
    bus.we       = 1'b0;
    bus.addr     = 32'h0;
    bus.sel      = 4'h0;
    bus.data_i   = 32'h0;
    bus.tx_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // reset state
    #1;
    check("rst_data_o", bus.data_o, 32'h0);
    check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
`ifdef DATA_RAM_MMIO_EN
    do_read("cycle_first", 32'hF000_0000, 32'd0);
    repeat (9) tick();
    do_read("cycle_plus10", 32'hF000_0000, 32'd10);
    do_read("rst_status", 32'hF000_0008, 32'h0000_0001);
    do_read("txdata_rd", 32'hF000_0004, 32'h0);
`endif

    // byte lanes
    do_write(32'h40, 32'hDEAD_BEEF, 4'b1111);
    do_read("lane_full", 32'h40, 32'hDEAD_BEEF);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.data_i = 32'h00AA_0000; bus.sel = 4'b0100;
    #1;
    check("wr_data_o_zero", bus.data_o, 32'h0);
    tick();
    bus.ce = 1'b0; bus.we = 1'b0;
    do_read("lane_merge", 32'h40, 32'hDEAA_BEEF);

    // aliasing and ce gating
    do_write(32'h0, 32'h1234_5678, 4'b1111);
    do_read("alias_1000", 32'h1000, 32'h1234_5678);
    bus.ce = 1'b0; bus.addr = 32'h0;
    #1;
    check("ce_low", bus.data_o, 32'h0);

    // random lane writes against a bench-side word model
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      model[i] = w;
      do_write(32'h100 + 32'(i * 4), w, 4'b1111);
    end
    for (int i = 0; i < 24; i++) begin
      idx = $urandom_range(0, 15);
      w   = $urandom;
      s   = 4'($urandom_range(0, 15));
      for (int l = 0; l < 4; l++)
        if (s[l]) model[idx][l*8 +: 8] = w[l*8 +: 8];
      do_write(32'h100 + 32'(idx * 4), w, s);
    end
    for (int i = 0; i < 16; i++) do_read("rand_word", 32'h100 + 32'(i * 4), model[i]);

`ifdef DATA_RAM_MMIO_EN
    // fill and overflow
    for (int b = 1; b <= 9; b++) begin
      if (b <= 8) tx_q.push_back(8'(b));
      do_write(32'hF000_0004, 32'(b), 4'b0001);
    end
    check("fill_head", {24'h0, bus.tx_data}, 32'h01);
    do_read("status_ovf", 32'hF000_0008, 32'h0000_0806);
    do_write(32'hF000_0008, 32'h0, 4'b0000);
    do_read("status_clr", 32'hF000_0008, 32'h0000_0802);
    drain("drain_byte", 40);
    do_read("status_empty", 32'hF000_0008, 32'h0000_0001);

    // full FIFO with simultaneous enqueue and dequeue
    for (int b = 0; b < 8; b++) begin
      tx_q.push_back(8'(8'h10 + b));
      do_write(32'hF000_0004, 32'(8'h10 + b), 4'b0001);
    end
    bus.tx_ready = 1'b1;
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'hF000_0004; bus.data_i = 32'h55; bus.sel = 4'b0001;
    tx_q.push_back(8'h55);
    #1;
    check("simul_head", {24'h0, bus.tx_data}, {24'h0, tx_q.pop_front()});
    tick();
    bus.ce = 1'b0; bus.we = 1'b0; bus.tx_ready = 1'b0;
    do_read("simul_status", 32'hF000_0008, 32'h0000_0802);
    drain("simul_byte", 40);

    // queued bytes before a mid-run reset
    for (int b = 0; b < 3; b++) do_write(32'hF000_0004, 32'(8'hA0 + b), 4'b0001);
    check("pre_rst_valid", {31'h0, bus.tx_valid}, 32'h1);
`else
    do_write(32'hF000_0004, 32'hAABB_CCDD, 4'b1111);
    do_read("nommio_word1", 32'h4, 32'hAABB_CCDD);
    do_read("nommio_word0", 32'hF000_0000, 32'h1234_5678);
    check("nommio_valid", {31'h0, bus.tx_valid}, 32'h0);
`endif

    // reset mid-run with a RAM write presented in the reset cycle
    rst = 1'b1;
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.data_i = 32'h0; bus.sel = 4'b1111;
    tick();
    rst = 1'b0;
    bus.ce = 1'b0; bus.we = 1'b0;
    tx_q.delete();
    check("midrst_valid", {31'h0, bus.tx_valid}, 32'h0);
`ifdef DATA_RAM_MMIO_EN
    do_read("midrst_status", 32'hF000_0008, 32'h0000_0001);
`endif
    do_read("midrst_ram", 32'h40, 32'hDEAA_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
